pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage Beta core.
- Decides each cycle the next-PC source, the PC write enable, and the instruction-register source for fetch and decode.
- Arbitrates, in priority order, between load-use stalls from decode, illegal-op traps, pending interrupts, and taken branches/jumps.
- Sits beside decode: consumes its op_*/zr/stall outputs and drives its ir_src_dec input.

Parameters:
- TRAP_CYCLES, 1, number of cycles after an exception injection during which IRQ is masked and decode emits NOPs (1..15).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- stall  in  1  load-use stall from decode
- op_jmp  in  1  JMP in decode
- op_beq  in  1  BEQ in decode
- op_bne  in  1  BNE in decode
- zr  in  1  decode RA operand is zero
- illop  in  1  decode holds an unimplemented opcode
- irq  in  1  level interrupt request, already synchronised to clk
- int_en  in  1  interrupts enabled (supervisor bit of pc_decode clear)
- pc_sel  out  3  0=PC+4, 1=branch target, 2=jump target, 3=ILLOP vector, 4=XADR vector
- pc_we  out  1  PC register update enable
- ir_src_if  out  2  fetch IR source: `IR_SRC_DATA / `IR_SRC_NOP
- ir_src_dec  out  2  decode IR source: `IR_SRC_DATA / `IR_SRC_NOP / `IR_SRC_EXCEPT
- irq_ack  out  1  one-cycle pulse when an interrupt is taken
- busy_trap  out  1  FSM in TRAP

Behaviour:
- Outputs are combinational from state and inputs. irq_pending, state and trap counter are registered.
- Reset (rst=1 sampled at posedge):
  - state=RUN, irq_pending=0, trap_cnt=0.
  - While rst is high: pc_we=0, pc_sel=0, ir_src_if=NOP, ir_src_dec=NOP, irq_ack=0, busy_trap=0.
  - Reset mid-trap aborts the trap. A pending IRQ is lost and is re-latched from the level input.
- irq_pending:
  - Set on any cycle with irq=1.
  - Cleared in the cycle irq_ack=1 (set wins only if irq is still high the next cycle).
- taken = op_jmp | (op_beq & zr) | (op_bne & ~zr).
- State RUN, first match wins:
  1. stall=1: pc_we=0, ir_src_if=DATA (refetch), ir_src_dec=NOP (bubble to exec). Branch, illop and irq decisions are deferred, not dropped.
  2. illop=1: pc_sel=3, pc_we=1, ir_src_if=NOP, ir_src_dec=EXCEPT. Go to TRAP with trap_cnt=TRAP_CYCLES.
  3. irq_pending & int_en: pc_sel=4, pc_we=1, ir_src_if=NOP, ir_src_dec=EXCEPT, irq_ack=1. Go to TRAP.
  4. taken: pc_sel = op_jmp ? 2 : 1, pc_we=1, ir_src_if=NOP (annul the wrong-path fetch), ir_src_dec=DATA.
  5. Otherwise: pc_sel=0, pc_we=1, ir_src_if=DATA, ir_src_dec=DATA.
- State TRAP:
  - busy_trap=1, pc_sel=0, pc_we=1, ir_src_if=DATA, ir_src_dec=NOP.
  - irq and illop are ignored. irq still latches into irq_pending.
  - trap_cnt decrements each cycle; when it reaches 1, return to RUN next cycle.
- stall is assumed low in TRAP (decode holds a NOP). If high, it still forces pc_we=0 and freezes trap_cnt.
- Simultaneous illop and taken: illop wins; the branch is discarded.
- Simultaneous irq and taken: interrupt wins. The branch instruction completes; XADR is taken in place of its target, and the saved return address points at the branch target's predecessor, per the Beta exception convention.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined:
  - Adds outputs stall_cnt, flush_cnt, trap_cnt_tot (each CNT_W wide, saturating at all-ones, cleared by rst).
  - stall_cnt increments on each RUN cycle with stall=1.
  - flush_cnt increments on each cycle with ir_src_if=NOP and rst=0.
  - trap_cnt_tot increments on each entry to TRAP.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Hold rst=1 for 3 cycles with irq=1 → pc_we=0, ir_src_if=NOP, ir_src_dec=NOP, irq_ack=0. First cycle after release with int_en=1 → pc_sel=4, irq_ack=1.
- op_beq=1, zr=1, stall=0 → pc_sel=1, ir_src_if=NOP, ir_src_dec=DATA. Repeat with zr=0 → pc_sel=0, ir_src_if=DATA.
- op_jmp=1 with stall=1 for 2 cycles, then stall=0 → two cycles of pc_we=0, ir_src_dec=NOP, ir_src_if=DATA; third cycle pc_sel=2, ir_src_if=NOP.
- illop=1, irq=1, op_jmp=1 together → pc_sel=3, ir_src_dec=EXCEPT, irq_ack=0. Next cycle (TRAP_CYCLES=1) busy_trap=1, ir_src_dec=NOP. Cycle after → pc_sel=4, irq_ack=1.
- irq=1 with int_en=0 for 5 cycles, then int_en=1 → no irq_ack while masked; irq_ack pulses exactly once on the first enabled cycle; with irq dropped, no second ack.
- With PIPE_CTRL_PERF_EN, CNT_W=4: 20 stall cycles → stall_cnt saturates at 15. Assert rst → all counters read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 5-stage Beta core.
// Selects next-PC source, PC write enable and fetch/decode IR sources each
// cycle. Priority in RUN is stall > illop > interrupt > taken branch/jump.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal issue; arbitrates stall, illop, irq, branch
// ST_TRAP  | exception just injected; irq masked, decode fed NOPs
//
// The IR source codes below are shared with decode; guard so that a project
// wide definition wins if one is already present.
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif

module pipe_ctrl #(
  parameter int unsigned TRAP_CYCLES = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       op_jmp,
  input  logic       op_beq,
  input  logic       op_bne,
  input  logic       zr,
  input  logic       illop,
  input  logic       irq,
  input  logic       int_en,
  output logic [2:0] pc_sel,
  output logic       pc_we,
  output logic [1:0] ir_src_if,
  output logic [1:0] ir_src_dec,
  output logic       irq_ack,
  output logic       busy_trap
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] trap_cnt_tot
`endif
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  localparam logic [2:0] PC_INC   = 3'd0;
  localparam logic [2:0] PC_BR    = 3'd1;
  localparam logic [2:0] PC_JMP   = 3'd2;
  localparam logic [2:0] PC_ILLOP = 3'd3;
  localparam logic [2:0] PC_XADR  = 3'd4;

  // Trap length is loaded on entry and counted down to 1.
  localparam logic [3:0] TRAP_INIT = 4'(TRAP_CYCLES);

  logic [0:0] state;
  logic [3:0] trap_cnt;
  logic       irq_pending;
  logic       taken;
  logic       irq_take;
  logic       enter_trap;

  assign taken = op_jmp | (op_beq & zr) | (op_bne & ~zr);

  // An interrupt raised this very cycle counts as pending, so a level irq
  // held through reset is serviced on the first cycle after release.
  assign irq_take = (irq_pending | irq) & int_en;

  // Output decode: combinational from state and current decode inputs.
  always_comb begin
    pc_sel     = PC_INC;
    pc_we      = 1'b0;
    ir_src_if  = `IR_SRC_NOP;
    ir_src_dec = `IR_SRC_NOP;
    irq_ack    = 1'b0;
    busy_trap  = 1'b0;
    enter_trap = 1'b0;
    if (!rst) begin
      if (state == ST_TRAP) begin
        busy_trap = 1'b1;
        pc_we     = ~stall;
        ir_src_if = `IR_SRC_DATA;
      end else if (stall) begin
        // Refetch the same word and bubble exec; all decisions wait.
        ir_src_if = `IR_SRC_DATA;
      end else if (illop) begin
        pc_sel     = PC_ILLOP;
        pc_we      = 1'b1;
        ir_src_dec = `IR_SRC_EXCEPT;
        enter_trap = 1'b1;
      end else if (irq_take) begin
        // Replaces a coincident branch target; the branch itself completes.
        pc_sel     = PC_XADR;
        pc_we      = 1'b1;
        ir_src_dec = `IR_SRC_EXCEPT;
        irq_ack    = 1'b1;
        enter_trap = 1'b1;
      end else if (taken) begin
        pc_sel     = op_jmp ? PC_JMP : PC_BR;
        pc_we      = 1'b1;
        ir_src_dec = `IR_SRC_DATA;
      end else begin
        pc_we      = 1'b1;
        ir_src_if  = `IR_SRC_DATA;
        ir_src_dec = `IR_SRC_DATA;
      end
    end
  end

  // State and trap countdown; a stall freezes the countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      trap_cnt <= 4'd0;
    end else if (state == ST_RUN) begin
      if (enter_trap) begin
        state    <= ST_TRAP;
        trap_cnt <= TRAP_INIT;
      end
    end else if (!stall) begin
      if (trap_cnt <= 4'd1) begin
        state    <= ST_RUN;
        trap_cnt <= 4'd0;
      end else begin
        trap_cnt <= trap_cnt - 4'd1;
      end
    end
  end

  // Interrupt latch: the ack cycle clears it, later irq cycles set it again.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pending <= 1'b0;
    end else if (irq_ack) begin
      irq_pending <= 1'b0;
    end else if (irq) begin
      irq_pending <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      trap_cnt_tot <= '0;
    end else begin
      if (state == ST_RUN && stall && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (ir_src_if == `IR_SRC_NOP && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_ONE;
      if (enter_trap && trap_cnt_tot != CNT_MAX)
        trap_cnt_tot <= trap_cnt_tot + CNT_ONE;
    end
  end
`endif

endmodule
